// File: rtl/psum_drain.sv
// psum_drain: east-edge collector for the systolic PE array. Captures each row's skewed
// final psum, requantises it (round/shift/saturate) and drains rows over valid/ready.
// Optional feature: define PSUM_DRAIN_RELU_EN to clamp negative results to zero.
module psum_drain #(
    parameter int ROWS      = 8,
    parameter int CAP_DELAY = 64,
    parameter int DATAWIDTH = 11,
    parameter int SHIFT     = 4
) (
    input  logic                              clk,
    input  logic                              rst_overall_n,
    input  logic                              start,
    input  logic [ROWS*2*DATAWIDTH-1:0]       row_psum,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic signed [DATAWIDTH-1:0]       out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              start_dropped
);

    localparam int PW     = 2 * DATAWIDTH;
    localparam int EW     = PW + 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = $clog2(CAP_DELAY + 1) + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND     = (SHIFT > 0) ? (EW'(1) << RND_SH) : '0;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DATAWIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [RW-1:0]               idx;
    logic [RW-1:0]               nxt;
    logic signed [DATAWIDTH-1:0] buf_q [ROWS];

    logic signed [PW-1:0]        lanes [ROWS];
    logic signed [PW-1:0]        cap_psum;
    logic signed [EW-1:0]        ext;
    logic signed [EW-1:0]        rnd_sum;
    logic signed [EW-1:0]        shifted;
    logic signed [DATAWIDTH-1:0] sat;
    logic signed [DATAWIDTH-1:0] q;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            lanes[r] = row_psum[r*PW +: PW];
        end
    end

    // The extra sign bit keeps the rounding add from wrapping near the psum extremes.
    always_comb begin
        cap_psum = lanes[idx];
        ext      = {cap_psum[PW-1], cap_psum};
        rnd_sum  = ext + RND;
        shifted  = rnd_sum >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATAWIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATAWIDTH-1:0];
        end else begin
            sat = shifted[DATAWIDTH-1:0];
        end
`ifdef PSUM_DRAIN_RELU_EN
        if (sat[DATAWIDTH-1]) begin
            q = '0;
        end else begin
            q = sat;
        end
`else
        q = sat;
`endif
    end

    assign nxt  = idx + 1'b1;
    assign busy = (state != IDLE);

    // idx is the capture lane in WAIT/CAPTURE and the drain row in DRAIN; it is 0 in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_overall_n) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_row       <= '0;
            out_last      <= 1'b0;
            done          <= 1'b0;
            start_dropped <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                buf_q[r] <= '0;
            end
        end else begin
            done          <= 1'b0;
            start_dropped <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                        idx   <= '0;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(CAP_DELAY)) begin
                        buf_q[0] <= q;
                        cnt      <= '0;
                        if (ROWS == 1) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_data  <= q;
                            out_row   <= '0;
                            out_last  <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                            idx   <= RW'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    buf_q[idx] <= q;
                    if (idx == RW'(ROWS - 1)) begin
                        state     <= DRAIN;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= buf_q[0];
                        out_row   <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        idx <= nxt;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx      <= nxt;
                            out_row  <= nxt;
                            out_data <= buf_q[nxt];
                            out_last <= (nxt == RW'(ROWS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: table-driven vectors, hand-written corner sequences and randomised passes
// for psum_drain, checked against a floor-division requantisation model.
module tb_psum_drain;

    localparam int ROWS      = 4;
    localparam int CAP_DELAY = 8;
    localparam int DATAWIDTH = 11;
    localparam int SHIFT     = 4;
    localparam int PW        = 2 * DATAWIDTH;

    logic                        clk = 1'b0;
    logic                        rst_overall_n;
    logic                        start;
    logic [ROWS*PW-1:0]          row_psum;
    logic                        out_ready;
    logic                        out_valid;
    logic signed [DATAWIDTH-1:0] out_data;
    logic [1:0]                  out_row;
    logic                        out_last;
    logic                        busy;
    logic                        done;
    logic                        start_dropped;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        logic [3:0][PW-1:0]        lanes;
        logic [3:0][DATAWIDTH-1:0] expv;
    } vec_t;

    vec_t vecs [4];

    psum_drain #(
        .ROWS(ROWS), .CAP_DELAY(CAP_DELAY), .DATAWIDTH(DATAWIDTH), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_overall_n(rst_overall_n), .start(start), .row_psum(row_psum),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .busy(busy), .done(done), .start_dropped(start_dropped)
    );

    always #5 clk = ~clk;

    // Round-half-up then floor division by 2^SHIFT, saturated (and ReLU'd when enabled).
    function automatic logic [DATAWIDTH-1:0] requant_model(input logic [PW-1:0] raw);
        longint p, t, qv, div, half, maxv, minv;
        logic [63:0] qbits;
        p    = longint'($signed(raw));
        div  = longint'(2) ** SHIFT;
        half = (SHIFT > 0) ? div / 2 : 0;
        maxv = (longint'(2) ** (DATAWIDTH - 1)) - 1;
        minv = -(longint'(2) ** (DATAWIDTH - 1));
        t    = p + half;
        qv   = (t >= 0) ? t / div : -((-t + div - 1) / div);
        if (qv > maxv) qv = maxv;
        if (qv < minv) qv = minv;
`ifdef PSUM_DRAIN_RELU_EN
        if (qv < 0) qv = 0;
`endif
        qbits = 64'(qv);
        return qbits[DATAWIDTH-1:0];
    endfunction

    task automatic checkOutput(input string tag, input string field,
                               input logic signed [31:0] act, input logic signed [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s.%s: got %0d expected %0d at %0t", tag, field, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int l0, input int l1, input int l2, input int l3,
                           input int e0, input int e1, input int e2, input int e3);
        vecs[i].lanes[0] = PW'(l0);
        vecs[i].lanes[1] = PW'(l1);
        vecs[i].lanes[2] = PW'(l2);
        vecs[i].lanes[3] = PW'(l3);
        vecs[i].expv[0]  = DATAWIDTH'(e0);
        vecs[i].expv[1]  = DATAWIDTH'(e1);
        vecs[i].expv[2]  = DATAWIDTH'(e2);
        vecs[i].expv[3]  = DATAWIDTH'(e3);
    endtask

    task automatic garbage_lanes();
        for (int r = 0; r < ROWS; r++) row_psum[r*PW +: PW] = PW'($urandom);
    endtask

    // ready_mode: 0 always ready, 1 fixed stall pattern, 2 random.
    task automatic applyStimulus(input string tag, input logic [3:0][PW-1:0] vals,
                                 input logic [3:0][DATAWIDTH-1:0] expv, input int ready_mode,
                                 input bit drop_wait, input bit drop_drain,
                                 input bit drop_last, input bit reset_mid);
        int cyc, hs, exp_row;
        bit ready_now, start_now;
        bit pattern [7];
        pattern = '{0, 0, 1, 0, 1, 1, 1};
        start = 1'b1;
        garbage_lanes();
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput(tag, "busy_after_start", busy, 1);
        checkOutput(tag, "done_after_start", done, 0);
        checkOutput(tag, "dropped_after_start", start_dropped, 0);
        for (int k = 1; k <= CAP_DELAY + ROWS - 1; k++) begin
            for (int r = 0; r < ROWS; r++) begin
                row_psum[r*PW +: PW] = (k == CAP_DELAY + r) ? vals[r] : PW'($urandom);
            end
            start = drop_wait && (k == 3);
            @(posedge clk); #1;
            checkOutput(tag, "capture_valid", out_valid, (k == CAP_DELAY + ROWS - 1) ? 1 : 0);
            checkOutput(tag, "capture_dropped", start_dropped, (drop_wait && k == 3) ? 1 : 0);
            checkOutput(tag, "capture_busy", busy, 1);
            start = 1'b0;
        end
        cyc = 0;
        hs = 0;
        exp_row = 0;
        while (hs < ROWS && cyc < 64 && !(reset_mid && hs == 2)) begin
            checkOutput(tag, "drain_valid", out_valid, 1);
            checkOutput(tag, "drain_row", out_row, exp_row);
            checkOutput(tag, "drain_data", out_data, $signed(expv[exp_row]));
            checkOutput(tag, "drain_last", out_last, (exp_row == ROWS - 1) ? 1 : 0);
            checkOutput(tag, "drain_done", done, 0);
            case (ready_mode)
                0:       ready_now = 1'b1;
                1:       ready_now = (cyc < 7) ? pattern[cyc] : 1'b1;
                default: ready_now = 1'($urandom_range(0, 1));
            endcase
            start_now = (drop_drain && cyc == 1) || (drop_last && exp_row == ROWS - 1 && ready_now);
            out_ready = ready_now;
            start = start_now;
            garbage_lanes();
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput(tag, "drain_dropped", start_dropped, start_now ? 1 : 0);
            if (ready_now) begin
                hs++;
                exp_row++;
            end
            cyc++;
        end
        out_ready = 1'b0;
        if (reset_mid) begin
            checkOutput(tag, "handshakes_before_reset", hs, 2);
            rst_overall_n = 1'b0;
            @(posedge clk); #1;
            rst_overall_n = 1'b1;
            checkOutput(tag, "reset_valid", out_valid, 0);
            checkOutput(tag, "reset_busy", busy, 0);
            checkOutput(tag, "reset_done", done, 0);
            @(posedge clk); #1;
            checkOutput(tag, "post_reset_done", done, 0);
            checkOutput(tag, "post_reset_valid", out_valid, 0);
        end else begin
            checkOutput(tag, "handshakes", hs, ROWS);
            checkOutput(tag, "end_done", done, 1);
            checkOutput(tag, "end_valid", out_valid, 0);
            checkOutput(tag, "end_busy", busy, 0);
            if (drop_last) begin
                @(posedge clk); #1;
                checkOutput(tag, "idle_done", done, 0);
                checkOutput(tag, "idle_busy", busy, 0);
                checkOutput(tag, "idle_dropped", start_dropped, 0);
            end
        end
    endtask

    initial begin
        logic [3:0][PW-1:0]        rvals;
        logic [3:0][DATAWIDTH-1:0] rexp;

        set_vec(0, 100, 200, 300, 400, 6, 13, 19, 25);
`ifdef PSUM_DRAIN_RELU_EN
        set_vec(1, -24, 2097151, -2097152, 7, 0, 1023, 0, 0);
        set_vec(2, 8, -9, 16375, 16376, 1, 0, 1023, 1023);
        set_vec(3, -16392, -16393, -8, 24, 0, 0, 0, 2);
`else
        set_vec(1, -24, 2097151, -2097152, 7, -1, 1023, -1024, 0);
        set_vec(2, 8, -9, 16375, 16376, 1, -1, 1023, 1023);
        set_vec(3, -16392, -16393, -8, 24, -1024, -1024, 0, 2);
`endif

        rst_overall_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        garbage_lanes();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", "out_valid", out_valid, 0);
        checkOutput("reset", "out_data", out_data, 0);
        checkOutput("reset", "out_row", out_row, 0);
        checkOutput("reset", "out_last", out_last, 0);
        checkOutput("reset", "busy", busy, 0);
        checkOutput("reset", "done", done, 0);
        checkOutput("reset", "start_dropped", start_dropped, 0);
        rst_overall_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle", "busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].lanes, vecs[i].expv, 0, 0, 0, 0, 0);
        end

        applyStimulus("backpressure", vecs[0].lanes, vecs[0].expv, 1, 0, 0, 0, 0);
        applyStimulus("start_busy", vecs[0].lanes, vecs[0].expv, 0, 1, 1, 1, 0);
        applyStimulus("reset_mid", vecs[1].lanes, vecs[1].expv, 0, 0, 0, 0, 1);
        applyStimulus("after_reset", vecs[0].lanes, vecs[0].expv, 0, 0, 0, 0, 0);

        for (int p = 0; p < 8; p++) begin
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 2))
                    0:       rvals[r] = PW'($urandom);
                    1:       rvals[r] = PW'(int'($urandom_range(0, 40000)) - 20000);
                    default: rvals[r] = PW'(int'($urandom_range(0, 64)) + 16340 - (($urandom_range(0, 1) == 1) ? 32760 : 0));
                endcase
                rexp[r] = requant_model(rvals[r]);
            end
            applyStimulus($sformatf("rand%0d", p), rvals, rexp, 2, 0, 0, 0, 0);
        end

        @(posedge clk); #1;
        checkOutput("final", "done", done, 0);
        checkOutput("final", "busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Downstream neighbour of the systolic PE row: sits on the east edge of the array and consumes the 2*DATAWIDTH partial sums leaving the last PE of each row.
- After a compute pass starts, captures each row's final dot product on that row's skewed cycle.
- Requantises each captured sum (round, shift, saturate) to DATAWIDTH.
- Drains the results one row at a time over a valid/ready stream.

Parameters:
- ROWS, 8, number of array rows / psum lanes.
- CAP_DELAY, 64, rising edges from start acceptance to row-0 capture (= array column count).
- DATAWIDTH, 11, PE operand width; psum width is 2*DATAWIDTH, output width is DATAWIDTH.
- SHIFT, 4, right-shift applied during requantisation, 0..2*DATAWIDTH-2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_overall_n  in  1  synchronous, active-low reset.
- start  in  1  pulse: array compute pass begins this cycle.
- row_psum  in  ROWS*2*DATAWIDTH  signed psums, lane r at bits [r*2*DATAWIDTH +: 2*DATAWIDTH].
- out_ready  in  1  consumer ready.
- out_valid  out  1  out_data valid.
- out_data  out  DATAWIDTH  signed requantised result.
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data.
- out_last  out  1  high with row ROWS-1.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last handshake.
- start_dropped  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (rst_overall_n=0 at a rising edge): state=IDLE, counters=0, result buffer=0, all outputs 0. Reset mid-pass discards all captured data; no done pulse.
- States: IDLE, WAIT, CAPTURE, DRAIN.
- IDLE: start=1 is accepted at edge t0 -> WAIT with cnt=1.
- WAIT: cnt increments each edge. At the edge where cnt==CAP_DELAY, capture lane 0 and go to CAPTURE.
- CAPTURE: lane r is captured at edge t0+CAP_DELAY+r, matching the one-row-per-cycle input skew. After lane ROWS-1 is captured -> DRAIN.
- Requantisation is applied at capture and stored as DATAWIDTH bits:
  - SHIFT>0: t = psum + 2^(SHIFT-1), computed at 2*DATAWIDTH+1 bits so the add cannot wrap; then arithmetic shift right by SHIFT.
  - SHIFT=0: t = psum.
  - Saturate t to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
- DRAIN:
  - out_valid goes high on the cycle after the last capture, with out_row=0.
  - out_data, out_row and out_last hold stable while out_valid=1 and out_ready=0.
  - Each out_valid&&out_ready edge advances to the next row.
  - Handshake with out_last=1 -> IDLE, and done=1 for exactly the next cycle.
  - Back-to-back: with out_ready held high, ROWS results take ROWS consecutive cycles.
- start while busy (WAIT/CAPTURE/DRAIN) is ignored, and start_dropped pulses the next cycle.
- start in the same cycle as the final handshake is also dropped. A new pass may start on the cycle done is high.
- row_psum is not sampled outside the capture edges.
- Minimum pass latency, start to first out_valid: CAP_DELAY+ROWS edges.

Optional Feature:
- Macro PSUM_DRAIN_RELU_EN.
- Defined: ReLU is applied after saturation, so any negative result is stored as 0.
- Undefined: signed results pass through unchanged.
- Handshake and timing are identical either way.

Test Plan:
- Bench config for all scenarios: ROWS=4, CAP_DELAY=8, DATAWIDTH=11, SHIFT=4.
- Basic pass: start at t0; lane r driven with 100*(r+1) only on edge t0+8+r, garbage elsewhere; out_ready=1 -> out_data 6,13,19,25 (rows 0..3) on 4 consecutive cycles, out_last on row 3, done one cycle later.
- Rounding and saturation, macro undefined: lanes -24, 2097151, -2097152, 7 -> outputs -1, 1023, -1024, 0.
- Backpressure: out_ready toggled 0,0,1,0,1,1,1 -> each row held stable while stalled, no row lost or repeated, exactly 4 handshakes, then done.
- Start while busy: start re-pulsed in WAIT and again in DRAIN -> start_dropped pulses each time, capture timing unchanged, single done.
- Reset mid-DRAIN after row 1 handshake: rst_overall_n=0 for one edge -> out_valid=0, busy=0, no done; a subsequent start runs a clean pass.
- ReLU (PSUM_DRAIN_RELU_EN defined): lanes -24, 2097151, -2097152, 7 -> outputs 0, 1023, 0, 0.
